// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcode/func values,
// FSM state encoding and the datapath mux/ALU control encodings.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SLT   = 6'd42;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, ALU_WB, JR_ST, EXEC_I, IMM_WB, MEM_ADDR,
    MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, JAL_ST, ILLEGAL
  } state_t;

  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_SLT = 2'd2} alu_op_t;
  typedef enum logic [1:0] {PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3} pc_src_t;
  typedef enum logic [1:0] {DST_RT = 2'd0, DST_RD = 2'd1, DST_R31 = 2'd2} reg_dst_t;
  typedef enum logic [1:0] {SRC_PC = 2'd0, SRC_MDR = 2'd1, SRC_ALUOUT = 2'd2} reg_src_t;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath/memory bundle.
// master: controller side (decode/status in, control strobes out).
// slave : datapath side (the reverse).
interface mcc_if;
  logic [5:0] opCode;
  logic [5:0] func;
  logic       zero;
  logic       memReady;
  logic       pcWrite;
  logic       IorD;
  logic       memRead;
  logic       memWrite;
  logic       irWrite;
  logic [1:0] regDst;
  logic [1:0] regSrc;
  logic       regWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] pcSrc;
  logic       instrDone;
  logic       illegal;

  modport master (
    input  opCode, func, zero, memReady,
    output pcWrite, IorD, memRead, memWrite, irWrite, regDst, regSrc,
           regWrite, ALUSrcA, ALUSrcB, ALUOp, pcSrc, instrDone, illegal
  );

  modport slave (
    output opCode, func, zero, memReady,
    input  pcWrite, IorD, memRead, memWrite, irWrite, regDst, regSrc,
           regWrite, ALUSrcA, ALUSrcB, ALUOp, pcSrc, instrDone, illegal
  );
endinterface

// File: rtl/multi_cycle_controller_alu_op_decoder.sv
// ALU operation select from (state, opCode, func).
// Ports: i_state, i_op_code, i_func in; o_alu_op out. Purely combinational.
module alu_op_decoder
  import mips_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_op_code,
  input  logic [5:0] i_func,
  output alu_op_t    o_alu_op
);

  always_comb begin
    o_alu_op = ALU_ADD;
    case (i_state)
      EXEC_R: begin
        if (i_func == FN_SUB)      o_alu_op = ALU_SUB;
        else if (i_func == FN_SLT) o_alu_op = ALU_SLT;
      end
      EXEC_I: begin
        if (i_op_code == OP_SLTI)  o_alu_op = ALU_SLT;
      end
      BRANCH:  o_alu_op = ALU_SUB;
      default: o_alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS control FSM.
// Ports: clk, rstN (async active-low); ctl (mcc_if.master) carries
// opCode/func/zero/memReady in and all datapath control strobes out.
//
// state     | meaning
// FETCH     | read instruction at PC, PC+4; waits on memReady
// DECODE    | branch target -> ALUOut, dispatch on opcode/func
// EXEC_R    | rs op rt
// ALU_WB    | R-type result -> rd
// JR_ST     | PC <- rs
// EXEC_I    | rs op imm
// IMM_WB    | I-type result -> rt
// MEM_ADDR  | rs + imm -> ALUOut
// MEM_READ  | load data, waits on memReady
// MEM_WB    | MDR -> rt
// MEM_WRITE | store, waits on memReady
// BRANCH    | compare rs/rt, conditional PC <- ALUOut
// JUMP      | PC <- jump target
// JAL_ST    | PC <- jump target, r31 <- PC
// ILLEGAL   | unsupported instruction, parked until reset
module multi_cycle_controller
  import mips_pkg::*;
(
  input logic   clk,
  input logic   rstN,
  mcc_if.master ctl
);

  state_t     r_state;
  state_t     w_next_state;
  alu_op_t    w_alu_op;
  pc_src_t    w_pc_src;
  reg_dst_t   w_reg_dst;
  reg_src_t   w_reg_src;
  logic [1:0] w_alu_src_b;
  logic       w_pc_write, w_iord, w_mem_read, w_mem_write, w_ir_write;
  logic       w_reg_write, w_alu_src_a, w_instr_done, w_illegal;

  alu_op_decoder u_alu_op_decoder (
    .i_state   (r_state),
    .i_op_code (ctl.opCode),
    .i_func    (ctl.func),
    .o_alu_op  (w_alu_op)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_pc_write   = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_dst    = DST_RT;
    w_reg_src    = SRC_PC;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_RT;
    w_pc_src     = PC_ALU;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        w_ir_write  = ctl.memReady;
        w_pc_write  = ctl.memReady;
        if (ctl.memReady) w_next_state = DECODE;
      end
      DECODE: begin
        w_alu_src_b = SRCB_IMM_SH2;
        case (ctl.opCode)
          OP_RTYPE: begin
            if (ctl.func == FN_ADD || ctl.func == FN_SUB || ctl.func == FN_SLT)
              w_next_state = EXEC_R;
            else if (ctl.func == FN_JR)
              w_next_state = JR_ST;
            else
              w_next_state = ILLEGAL;
          end
          OP_ADDI, OP_SLTI: w_next_state = EXEC_I;
          OP_LW, OP_SW:     w_next_state = MEM_ADDR;
          OP_BEQ, OP_BNE:   w_next_state = BRANCH;
          OP_J:             w_next_state = JUMP;
          OP_JAL:           w_next_state = JAL_ST;
          default:          w_next_state = ILLEGAL;
        endcase
      end
      EXEC_R: begin
        w_alu_src_a  = 1'b1;
        w_next_state = ALU_WB;
      end
      ALU_WB: begin
        w_reg_dst    = DST_RD;
        w_reg_src    = SRC_ALUOUT;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next_state = FETCH;
      end
      JR_ST: begin
        w_pc_src     = PC_RS;
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
        w_next_state = FETCH;
      end
      EXEC_I: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_IMM;
        w_next_state = IMM_WB;
      end
      IMM_WB: begin
        w_reg_src    = SRC_ALUOUT;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next_state = FETCH;
      end
      MEM_ADDR: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_IMM;
        w_next_state = (ctl.opCode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
        if (ctl.memReady) w_next_state = MEM_WB;
      end
      MEM_WB: begin
        w_reg_src    = SRC_MDR;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next_state = FETCH;
      end
      MEM_WRITE: begin
        w_iord       = 1'b1;
        w_mem_write  = 1'b1;
        w_instr_done = ctl.memReady;
        if (ctl.memReady) w_next_state = FETCH;
      end
      BRANCH: begin
        w_alu_src_a  = 1'b1;
        w_pc_src     = PC_ALUOUT;
        w_pc_write   = (ctl.opCode == OP_BEQ) ? ctl.zero : ~ctl.zero;
        w_instr_done = 1'b1;
        w_next_state = FETCH;
      end
      JUMP: begin
        w_pc_src     = PC_JUMP;
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
        w_next_state = FETCH;
      end
      JAL_ST: begin
        // PC was already incremented in FETCH, so SRC_PC is the return address.
        w_pc_src     = PC_JUMP;
        w_pc_write   = 1'b1;
        w_reg_dst    = DST_R31;
        w_reg_src    = SRC_PC;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next_state = FETCH;
      end
      ILLEGAL: w_illegal = 1'b1;
      default: w_next_state = FETCH;
    endcase
  end

  // Outputs are masked by rstN so they drop the instant reset asserts,
  // even though FETCH itself would otherwise request a read.
  assign ctl.pcWrite   = w_pc_write   & rstN;
  assign ctl.IorD      = w_iord       & rstN;
  assign ctl.memRead   = w_mem_read   & rstN;
  assign ctl.memWrite  = w_mem_write  & rstN;
  assign ctl.irWrite   = w_ir_write   & rstN;
  assign ctl.regDst    = w_reg_dst    & {2{rstN}};
  assign ctl.regSrc    = w_reg_src    & {2{rstN}};
  assign ctl.regWrite  = w_reg_write  & rstN;
  assign ctl.ALUSrcA   = w_alu_src_a  & rstN;
  assign ctl.ALUSrcB   = w_alu_src_b  & {2{rstN}};
  assign ctl.ALUOp     = w_alu_op     & {2{rstN}};
  assign ctl.pcSrc     = w_pc_src     & {2{rstN}};
  assign ctl.instrDone = w_instr_done & rstN;
  assign ctl.illegal   = w_illegal    & rstN;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: a per-instruction reference model
// expands each instruction into its expected cycle-by-cycle control words,
// driven from a directed table, hand-written reset/illegal sequences and a
// randomized instruction stream.
module tb_multi_cycle_controller;

  typedef struct packed {
    logic       pcWrite;
    logic       IorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] regDst;
    logic [1:0] regSrc;
    logic       regWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] pcSrc;
    logic       instrDone;
    logic       illegal;
  } out_t;

  typedef struct {
    logic rdy;
    logic zr;
    logic stable;
    out_t exp;
  } step_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       zr;
    int         fw;
    int         mw;
    int         lat;
  } vec_t;

  logic  clk = 1'b0;
  logic  rstN = 1'b0;
  int    total = 0;
  int    bad = 0;
  step_t q[$];
  vec_t  tbl[13];

  mcc_if u_if ();

  multi_cycle_controller dut (
    .clk  (clk),
    .rstN (rstN),
    .ctl  (u_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic out_t sample();
    out_t o;
    o.pcWrite   = u_if.pcWrite;
    o.IorD      = u_if.IorD;
    o.memRead   = u_if.memRead;
    o.memWrite  = u_if.memWrite;
    o.irWrite   = u_if.irWrite;
    o.regDst    = u_if.regDst;
    o.regSrc    = u_if.regSrc;
    o.regWrite  = u_if.regWrite;
    o.ALUSrcA   = u_if.ALUSrcA;
    o.ALUSrcB   = u_if.ALUSrcB;
    o.ALUOp     = u_if.ALUOp;
    o.pcSrc     = u_if.pcSrc;
    o.instrDone = u_if.instrDone;
    o.illegal   = u_if.illegal;
    return o;
  endfunction

  function automatic void push(input logic rdy, input logic zr, input logic stable, input out_t e);
    step_t s;
    s.rdy = rdy; s.zr = zr; s.stable = stable; s.exp = e;
    q.push_back(s);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Reference model: expected control words for one instruction, fw fetch
  // wait cycles and mw data-memory wait cycles.
  function automatic void build(input logic [5:0] op, input logic [5:0] fn,
                                input logic zr, input int fw, input int mw);
    out_t e;
    q.delete();
    for (int i = 0; i < fw; i++) begin
      e = '0; e.memRead = 1; e.ALUSrcB = 2'd1;
      push(1'b0, rb(), 1'b0, e);
    end
    e = '0; e.memRead = 1; e.ALUSrcB = 2'd1; e.irWrite = 1; e.pcWrite = 1;
    push(1'b1, rb(), 1'b0, e);
    e = '0; e.ALUSrcB = 2'd3;
    push(rb(), rb(), 1'b1, e);
    e = '0;
    if (op == 0 && fn == 8) begin
      e.pcWrite = 1; e.pcSrc = 2'd3; e.instrDone = 1;
      push(rb(), rb(), 1'b1, e);
    end else if (op == 0 && (fn == 32 || fn == 34 || fn == 42)) begin
      e.ALUSrcA = 1;
      e.ALUOp = (fn == 34) ? 2'd1 : (fn == 42) ? 2'd2 : 2'd0;
      push(rb(), rb(), 1'b1, e);
      e = '0; e.regDst = 2'd1; e.regSrc = 2'd2; e.regWrite = 1; e.instrDone = 1;
      push(rb(), rb(), 1'b1, e);
    end else if (op == 8 || op == 10) begin
      e.ALUSrcA = 1; e.ALUSrcB = 2'd2; e.ALUOp = (op == 10) ? 2'd2 : 2'd0;
      push(rb(), rb(), 1'b1, e);
      e = '0; e.regSrc = 2'd2; e.regWrite = 1; e.instrDone = 1;
      push(rb(), rb(), 1'b1, e);
    end else if (op == 35 || op == 43) begin
      e.ALUSrcA = 1; e.ALUSrcB = 2'd2;
      push(rb(), rb(), 1'b1, e);
      e = '0; e.IorD = 1;
      if (op == 35) e.memRead = 1; else e.memWrite = 1;
      for (int i = 0; i < mw; i++) push(1'b0, rb(), 1'b1, e);
      if (op == 43) e.instrDone = 1;
      push(1'b1, rb(), 1'b1, e);
      if (op == 35) begin
        e = '0; e.regSrc = 2'd1; e.regWrite = 1; e.instrDone = 1;
        push(rb(), rb(), 1'b1, e);
      end
    end else if (op == 4 || op == 5) begin
      e.pcWrite = (op == 4) ? zr : !zr;
      e.ALUSrcA = 1; e.ALUOp = 2'd1; e.pcSrc = 2'd1; e.instrDone = 1;
      push(rb(), zr, 1'b1, e);
    end else if (op == 2 || op == 3) begin
      e.pcWrite = 1; e.pcSrc = 2'd2; e.instrDone = 1;
      if (op == 3) begin e.regDst = 2'd2; e.regSrc = 2'd0; e.regWrite = 1; end
      push(rb(), rb(), 1'b1, e);
    end else begin
      e.illegal = 1;
      push(rb(), rb(), 1'b1, e);
    end
  endfunction

  function automatic int base_lat(input logic [5:0] op, input logic [5:0] fn);
    if (op == 35) return 5;
    if ((op == 0 && fn == 8) || op == 2 || op == 3 || op == 4 || op == 5) return 3;
    return 4;
  endfunction

  function automatic bit legal_op(input logic [5:0] op);
    return op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd10, 6'd35, 6'd43};
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = sample();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply(input string name, input logic [5:0] op, input logic [5:0] fn, input int lat);
    out_t act;
    int   done_at;
    done_at = 0;
    foreach (q[i]) begin
      @(negedge clk);
      u_if.memReady = q[i].rdy;
      u_if.zero     = q[i].zr;
      if (q[i].stable) begin
        u_if.opCode = op; u_if.func = fn;
      end else begin
        u_if.opCode = 6'($urandom); u_if.func = 6'($urandom);
      end
      #1;
      act = sample();
      total++;
      if (act !== q[i].exp) begin
        bad++;
        $display("FAIL %s op=%0d fn=%0d cycle %0d: got %h want %h", name, op, fn, i, act, q[i].exp);
      end
      if (act.instrDone === 1'b1 && done_at == 0) done_at = i + 1;
    end
    if (lat > 0) begin
      total++;
      if (done_at != lat) begin
        bad++;
        $display("FAIL %s latency op=%0d fn=%0d: got %0d cycles want %0d", name, op, fn, done_at, lat);
      end
    end
  endtask

  // Release reset with memReady low so FETCH holds across the next edge.
  task automatic release_reset(input string name);
    out_t e;
    @(negedge clk);
    u_if.memReady = 1'b0;
    rstN = 1'b1;
    #1;
    e = '0; e.memRead = 1; e.ALUSrcB = 2'd1;
    check(name, e);
  endtask

  task automatic run_illegal(input logic [5:0] op, input logic [5:0] fn, input int hold);
    out_t e;
    build(op, fn, 1'b0, 0, 0);
    e = '0; e.illegal = 1;
    for (int i = 1; i < hold; i++) push(rb(), rb(), 1'b1, e);
    apply("illegal_hold", op, fn, 0);
    @(posedge clk);
    #3;
    rstN = 1'b0;
    #1;
    check("illegal_async_reset", '0);
    release_reset("illegal_restart_fetch");
  endtask

  initial begin
    out_t z;
    z = '0;
    u_if.opCode = '0; u_if.func = '0; u_if.zero = 1'b0; u_if.memReady = 1'b0;

    tbl[0]  = '{6'd0,  6'd32, 1'b0, 0, 0, 4};
    tbl[1]  = '{6'd0,  6'd34, 1'b0, 1, 0, 5};
    tbl[2]  = '{6'd0,  6'd42, 1'b1, 0, 0, 4};
    tbl[3]  = '{6'd0,  6'd8,  1'b0, 0, 0, 3};
    tbl[4]  = '{6'd8,  6'd5,  1'b0, 0, 0, 4};
    tbl[5]  = '{6'd10, 6'd0,  1'b0, 2, 0, 6};
    tbl[6]  = '{6'd35, 6'd0,  1'b0, 2, 2, 9};
    tbl[7]  = '{6'd43, 6'd0,  1'b0, 0, 1, 5};
    tbl[8]  = '{6'd4,  6'd0,  1'b0, 0, 0, 3};
    tbl[9]  = '{6'd4,  6'd0,  1'b1, 0, 0, 3};
    tbl[10] = '{6'd5,  6'd0,  1'b0, 0, 0, 3};
    tbl[11] = '{6'd2,  6'd0,  1'b0, 0, 0, 3};
    tbl[12] = '{6'd3,  6'd0,  1'b0, 0, 0, 3};

    #1;
    check("reset_state", z);
    repeat (2) @(negedge clk);
    release_reset("reset_release_fetch");

    foreach (tbl[i]) begin
      build(tbl[i].op, tbl[i].fn, tbl[i].zr, tbl[i].fw, tbl[i].mw);
      apply("table", tbl[i].op, tbl[i].fn, tbl[i].lat);
    end

    run_illegal(6'd63, 6'd0, 12);
    run_illegal(6'd0, 6'd13, 3);

    // SW interrupted by reset while the store is stalled.
    build(6'd43, 6'd0, 1'b0, 0, 3);
    while (q.size() > 4) void'(q.pop_back());
    apply("sw_before_reset", 6'd43, 6'd0, 0);
    #2;
    rstN = 1'b0;
    #1;
    check("sw_reset_memwrite_drop", z);
    @(negedge clk);
    #1;
    check("sw_reset_held", z);
    release_reset("sw_restart_fetch");
    build(6'd0, 6'd32, 1'b0, 0, 0);
    apply("add_after_reset", 6'd0, 6'd32, 4);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        logic [5:0] bop;
        bop = 6'd63;
        for (int t = 0; t < 100; t++) begin
          logic [5:0] cand;
          cand = 6'($urandom);
          if (!legal_op(cand)) begin
            bop = cand;
            break;
          end
        end
        run_illegal(bop, 6'($urandom), $urandom_range(1, 4));
      end else begin
        logic [5:0] ops[13];
        logic [5:0] fns[13];
        int k, fw, mw;
        logic [5:0] op, fn;
        ops = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd8, 6'd10, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3, 6'd8};
        fns = '{6'd32, 6'd34, 6'd42, 6'd8, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1};
        k  = $urandom_range(0, 12);
        op = ops[k];
        fn = (op == 0) ? fns[k] : 6'($urandom);
        fw = $urandom_range(0, 2);
        mw = (op == 35 || op == 43) ? $urandom_range(0, 2) : 0;
        build(op, fn, rb(), fw, mw);
        apply("random", op, fn, base_lat(op, fn) + fw + mw);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
